// File: rtl/controlador_escritura_banco_pkg.sv
// Shared types and sizes for the register-bank write controller.
// Latency: n/a (declarations only).
// Backpressure: n/a. Exports NREG/AW/DW and the writeback request record wb_req_t.
package pkg_jericalla;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;

  // One writeback request; both sources (ALU and load) use the same shape.
  typedef struct packed {
    logic          valid;
    logic [AW-1:0] wa;
    logic [DW-1:0] dw;
  } wb_req_t;

endpackage

// File: rtl/controlador_escritura_banco_if.sv
// Bundle of writeback requests, decode scoreboard checks and bank write port.
// Latency: n/a (wiring only).
// Backpressure: readyN is the grant for reqN; master = pipeline side, slave = controller.
interface controlador_escritura_banco_if;
  import pkg_jericalla::*;

  wb_req_t         req0;        // ALU writeback
  wb_req_t         req1;        // load writeback
  logic            req0_ready;
  logic            req1_ready;
  logic            issue_valid; // decode reserves issue_wa
  logic [AW-1:0]   issue_wa;
  logic [AW-1:0]   ra1_chk;
  logic [AW-1:0]   ra2_chk;
  logic            stall;
  logic            issue_err;
  logic [NREG-1:0] busy_vec;
  logic            we_banco;
  logic [AW-1:0]   wa_banco;
  logic [DW-1:0]   dw_banco;

  modport master (
    output req0, req1, issue_valid, issue_wa, ra1_chk, ra2_chk,
    input  req0_ready, req1_ready, stall, issue_err, busy_vec,
           we_banco, wa_banco, dw_banco
  );

  modport slave (
    input  req0, req1, issue_valid, issue_wa, ra1_chk, ra2_chk,
    output req0_ready, req1_ready, stall, issue_err, busy_vec,
           we_banco, wa_banco, dw_banco
  );

endinterface

// File: rtl/controlador_escritura_banco_arbitro_rr2.sv
// Two-way round-robin arbiter; gnt_o one-hot or zero, combinational from req_i and LAST.
// Latency: 0 cycles request->grant; LAST updates on the edge where advance_i is high.
// Backpressure: a loser waits at most one cycle. Ports: clk_i, rst_n_i, req_i, advance_i, gnt_o.
module arbitro_rr2 (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] gnt_o
);

  logic last_q, last_d;

  always_comb begin
    gnt_o  = 2'b00;
    last_d = last_q;
    unique case (req_i)
      2'b01:   gnt_o = 2'b01;
      2'b10:   gnt_o = 2'b10;
      // Conflict: the requester that did not win last time goes first.
      2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
      default: gnt_o = 2'b00;
    endcase
    if (advance_i && (gnt_o != 2'b00)) last_d = gnt_o[1];
  end

  // LAST=1 out of reset so requester 0 wins the first conflict.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) last_q <= 1'b1;
    else          last_q <= last_d;
  end

endmodule

// File: rtl/controlador_escritura_banco.sv
// Shares the single bank write port between ALU and load writeback; keeps a pending-write scoreboard.
// Latency: 1 cycle from accepted request to WE/WA/DW; STALL is combinational from registered BUSY.
// Backpressure: readyN = round-robin grant (forced 0 in reset). Ports: clk_i, rst_n_i, bus_if (slave).
module controlador_escritura_banco
  import pkg_jericalla::*;
(
  input  logic                         clk_i,
  input  logic                         rst_n_i,
  controlador_escritura_banco_if.slave bus_if
);

  logic [1:0]      gnt;
  logic            xfer;
  logic [AW-1:0]   win_wa;
  logic [DW-1:0]   win_dw;
  logic [NREG-1:0] set_vec, clr_vec;

  logic            we_q, we_d;
  logic [AW-1:0]   wa_q, wa_d;
  logic [DW-1:0]   dw_q, dw_d;
  logic [NREG-1:0] busy_q, busy_d;
  logic            err_q, err_d;

  arbitro_rr2 u_arbitro (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .req_i     ({bus_if.req1.valid, bus_if.req0.valid}),
    .advance_i (xfer),
    .gnt_o     (gnt)
  );

  // A grant is only ever given to a valid requester, so any grant is a transfer.
  assign xfer              = |gnt;
  assign bus_if.req0_ready = gnt[0] & rst_n_i;
  assign bus_if.req1_ready = gnt[1] & rst_n_i;

  always_comb begin
    win_wa  = gnt[1] ? bus_if.req1.wa : bus_if.req0.wa;
    win_dw  = gnt[1] ? bus_if.req1.dw : bus_if.req0.dw;
    // Writes to r0 are accepted but never reach the bank.
    we_d    = xfer && (win_wa != '0);
    wa_d    = we_d ? win_wa : wa_q;
    dw_d    = we_d ? win_dw : dw_q;

    set_vec = '0;
    if (bus_if.issue_valid && (bus_if.issue_wa != '0)) set_vec[bus_if.issue_wa] = 1'b1;
    clr_vec = '0;
    if (we_d) clr_vec[win_wa] = 1'b1;

    // Set after clear: a same-edge reissue means a newer producer is outstanding.
    busy_d  = (busy_q & ~clr_vec) | set_vec;
    err_d   = (set_vec & busy_q & ~clr_vec) != '0;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      we_q   <= 1'b0;
      wa_q   <= '0;
      dw_q   <= '0;
      busy_q <= '0;
      err_q  <= 1'b0;
    end else begin
      we_q   <= we_d;
      wa_q   <= wa_d;
      dw_q   <= dw_d;
      busy_q <= busy_d;
      err_q  <= err_d;
    end
  end

  // busy_q[0] is never set, so r0 always reads not-busy. No stall in the
  // clearing cycle: the bank's write-through forwards the new value.
  assign bus_if.stall     = busy_q[bus_if.ra1_chk] | busy_q[bus_if.ra2_chk];
  assign bus_if.issue_err = err_q;
  assign bus_if.busy_vec  = busy_q;
  assign bus_if.we_banco  = we_q;
  assign bus_if.wa_banco  = wa_q;
  assign bus_if.dw_banco  = dw_q;

endmodule

// File: tb/tb_controlador_escritura_banco.sv
// Directed table-driven bench for controlador_escritura_banco plus reset corner sequences.
// Latency: inputs driven at negedge; comb outputs checked #1 later, registered outputs #1 after posedge.
// Backpressure: expected grants are hand-computed from the round-robin history of the table.
module tb_controlador_escritura_banco;
  import pkg_jericalla::*;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  controlador_escritura_banco_if bus_if ();

  controlador_escritura_banco dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus_if  (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0v;  logic [4:0] r0wa; logic [31:0] r0dw;
    logic        r1v;  logic [4:0] r1wa; logic [31:0] r1dw;
    logic        iv;   logic [4:0] iwa;
    logic [4:0]  ra1;  logic [4:0] ra2;
    logic        x_rdy0; logic x_rdy1; logic x_stall;
    logic        x_we; logic [4:0] x_wa; logic [31:0] x_dw;
    logic [31:0] x_busy; logic x_err;
  } vec_t;

  localparam int NV = 18;
  vec_t vt [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0v, input logic [4:0] r0wa, input logic [31:0] r0dw,
                       input logic r1v, input logic [4:0] r1wa, input logic [31:0] r1dw,
                       input logic iv, input logic [4:0] iwa,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    bus_if.req0        = '{valid: r0v, wa: r0wa, dw: r0dw};
    bus_if.req1        = '{valid: r1v, wa: r1wa, dw: r1dw};
    bus_if.issue_valid = iv;
    bus_if.issue_wa    = iwa;
    bus_if.ra1_chk     = ra1;
    bus_if.ra2_chk     = ra2;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    //     r0v   r0wa  r0dw           r1v   r1wa  r1dw       iv    iwa   ra1   ra2    rdy0  rdy1  stall  we    wa    dw             busy          err
    vt[0]  = '{1'b1,5'd5,32'hDEADBEEF, 1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b1,5'd5,32'hDEADBEEF,32'h0,       1'b0};
    vt[1]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,5'd5,32'hDEADBEEF,32'h0,       1'b0};
    vt[2]  = '{1'b0,5'd0,32'h0,        1'b1,5'd3,32'h33,    1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0, 1'b1,5'd3,32'h33,      32'h0,       1'b0};
    vt[3]  = '{1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b1,5'd1,32'h11,      32'h0,       1'b0};
    vt[4]  = '{1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0, 1'b1,5'd2,32'h22,      32'h0,       1'b0};
    vt[5]  = '{1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    1'b0,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b1,5'd1,32'h11,      32'h0,       1'b0};
    vt[6]  = '{1'b1,5'd1,32'h11,       1'b1,5'd2,32'h22,    1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b1,1'b0, 1'b1,5'd2,32'h22,      32'h0,       1'b0};
    vt[7]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd0, 1'b0,1'b0,1'b0, 1'b0,5'd2,32'h22,      32'h0,       1'b0};
    vt[8]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,5'd7, 5'd7,5'd0, 1'b0,1'b0,1'b0, 1'b0,5'd2,32'h22,      32'h80,      1'b0};
    vt[9]  = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b1, 1'b0,5'd2,32'h22,      32'h80,      1'b0};
    vt[10] = '{1'b0,5'd0,32'h0,        1'b1,5'd7,32'h77,    1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b1,1'b1, 1'b1,5'd7,32'h77,      32'h0,       1'b0};
    vt[11] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd7,5'd0, 1'b0,1'b0,1'b0, 1'b0,5'd7,32'h77,      32'h0,       1'b0};
    vt[12] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,5'd9, 5'd0,5'd9, 1'b0,1'b0,1'b0, 1'b0,5'd7,32'h77,      32'h200,     1'b0};
    vt[13] = '{1'b1,5'd9,32'h99,       1'b0,5'd0,32'h0,     1'b1,5'd9, 5'd0,5'd9, 1'b1,1'b0,1'b1, 1'b1,5'd9,32'h99,      32'h200,     1'b0};
    vt[14] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b1,5'd9, 5'd0,5'd9, 1'b0,1'b0,1'b1, 1'b0,5'd9,32'h99,      32'h200,     1'b1};
    vt[15] = '{1'b0,5'd0,32'h0,        1'b0,5'd0,32'h0,     1'b0,5'd0, 5'd0,5'd9, 1'b0,1'b0,1'b1, 1'b0,5'd9,32'h99,      32'h200,     1'b0};
    vt[16] = '{1'b1,5'd0,32'h1234,     1'b0,5'd0,32'h0,     1'b1,5'd0, 5'd0,5'd0, 1'b1,1'b0,1'b0, 1'b0,5'd9,32'h99,      32'h200,     1'b0};
    vt[17] = '{1'b0,5'd0,32'h0,        1'b1,5'd9,32'hA9,    1'b0,5'd0, 5'd0,5'd9, 1'b0,1'b1,1'b1, 1'b1,5'd9,32'hA9,      32'h0,       1'b0};

    // Reset state, with a request pending so READY gating is visible.
    rst_n = 1'b0;
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    #3;
    chk("rst_we",   {31'h0, bus_if.we_banco},   32'h0);
    chk("rst_wa",   {27'h0, bus_if.wa_banco},   32'h0);
    chk("rst_dw",   bus_if.dw_banco,            32'h0);
    chk("rst_busy", bus_if.busy_vec,            32'h0);
    chk("rst_err",  {31'h0, bus_if.issue_err},  32'h0);
    chk("rst_rdy0", {31'h0, bus_if.req0_ready}, 32'h0);
    #4 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(vt[i].r0v, vt[i].r0wa, vt[i].r0dw, vt[i].r1v, vt[i].r1wa, vt[i].r1dw,
            vt[i].iv, vt[i].iwa, vt[i].ra1, vt[i].ra2);
      #1;
      chk($sformatf("v%0d_rdy0", i),  {31'h0, bus_if.req0_ready}, {31'h0, vt[i].x_rdy0});
      chk($sformatf("v%0d_rdy1", i),  {31'h0, bus_if.req1_ready}, {31'h0, vt[i].x_rdy1});
      chk($sformatf("v%0d_stall", i), {31'h0, bus_if.stall},      {31'h0, vt[i].x_stall});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_we", i),   {31'h0, bus_if.we_banco},  {31'h0, vt[i].x_we});
      chk($sformatf("v%0d_wa", i),   {27'h0, bus_if.wa_banco},  {27'h0, vt[i].x_wa});
      chk($sformatf("v%0d_dw", i),   bus_if.dw_banco,           vt[i].x_dw);
      chk($sformatf("v%0d_busy", i), bus_if.busy_vec,           vt[i].x_busy);
      chk($sformatf("v%0d_err", i),  {31'h0, bus_if.issue_err}, {31'h0, vt[i].x_err});
    end

    // Build BUSY=0x84 with a write in flight, then reset mid-cycle.
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd2, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 5'd0);
    @(negedge clk);
    drive(1'b1, 5'd4, 32'h44, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd7, 5'd0);
    @(posedge clk);
    #1;
    chk("pre_rst_we",   {31'h0, bus_if.we_banco}, 32'h1);
    chk("pre_rst_wa",   {27'h0, bus_if.wa_banco}, 32'h4);
    chk("pre_rst_busy", bus_if.busy_vec,          32'h84);
    chk("pre_rst_stall", {31'h0, bus_if.stall},   32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_we",    {31'h0, bus_if.we_banco},   32'h0);
    chk("mid_rst_wa",    {27'h0, bus_if.wa_banco},   32'h0);
    chk("mid_rst_dw",    bus_if.dw_banco,            32'h0);
    chk("mid_rst_busy",  bus_if.busy_vec,            32'h0);
    chk("mid_rst_stall", {31'h0, bus_if.stall},      32'h0);
    chk("mid_rst_rdy0",  {31'h0, bus_if.req0_ready}, 32'h0);

    // After release the first conflict must go to requester 0.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 5'd0, 5'd0);
    #1;
    chk("post_rst_rdy0", {31'h0, bus_if.req0_ready}, 32'h1);
    chk("post_rst_rdy1", {31'h0, bus_if.req1_ready}, 32'h0);
    @(posedge clk);
    #1;
    chk("post_rst_we", {31'h0, bus_if.we_banco}, 32'h1);
    chk("post_rst_wa", {27'h0, bus_if.wa_banco}, 32'h1);
    chk("post_rst_dw", bus_if.dw_banco,          32'h11);

    @(negedge clk);
    drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 5'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/controlador_escritura_banco.md
Name: controlador_escritura_banco

Overview:
- Sequences the single write port of the 32x32 register bank (BancoRegistros) so that two writeback sources can share it.
- Requester 0 is the ALU writeback path; requester 1 is the load/memory writeback path.
- Arbitrates the two sources round-robin and drives WE/WA/DW of the bank from registers.
- Keeps a pending-write scoreboard, so the decode stage can stall reads of registers whose producer has not yet written back.

Parameters:
- NREG, 32, number of architectural registers.
- AW, 5, register address width (log2 NREG).
- DW, 32, data width.

Ports:
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous active-low reset.
- REQ0_VALID  in  1  ALU writeback request.
- REQ0_WA  in  AW  ALU destination register.
- REQ0_DW  in  DW  ALU write data.
- REQ0_READY  out  1  grant to requester 0 this cycle.
- REQ1_VALID  in  1  load writeback request.
- REQ1_WA  in  AW  load destination register.
- REQ1_DW  in  DW  load write data.
- REQ1_READY  out  1  grant to requester 1 this cycle.
- ISSUE_VALID  in  1  decode issues an instruction that will write ISSUE_WA.
- ISSUE_WA  in  AW  destination being reserved.
- RA1_CHK  in  AW  source register 1 of the instruction in decode.
- RA2_CHK  in  AW  source register 2 of the instruction in decode.
- STALL  out  1  a checked source register is pending.
- ISSUE_ERR  out  1  one-cycle pulse: issue to an already-busy register.
- BUSY_VEC  out  NREG  scoreboard bits.
- WE_BANCO  out  1  bank write enable.
- WA_BANCO  out  AW  bank write address.
- DW_BANCO  out  DW  bank write data.

Behaviour:
- Reset (RST_N=0, asynchronous):
  - WE_BANCO=0, WA_BANCO=0, DW_BANCO=0.
  - BUSY_VEC=0, ISSUE_ERR=0.
  - Round-robin pointer LAST=1, so requester 0 wins the first conflict.
  - READY outputs forced 0 while reset is asserted.
- Handshake:
  - A transfer occurs at a rising edge with VALID&&READY.
  - A requester holds VALID, WA and DW stable until accepted; it never drops VALID before acceptance.
  - READYx is combinational from the VALIDs and LAST; no combinational path from READY back to VALID.
- Arbitration:
  - Only one VALID asserted: grant it.
  - Both asserted: grant the requester other than LAST.
  - LAST updates to the granted index on each transfer and holds otherwise.
  - Starvation bound: 1 cycle.
- Write port, latency 1:
  - A transfer at edge N drives WE_BANCO=1 with WA/DW of the winner during cycle N..N+1.
  - WE_BANCO is low in any cycle following an edge with no transfer.
  - WA_BANCO and DW_BANCO hold their last values when WE_BANCO is low.
- Register 0:
  - Writes to address 0 are accepted (READY=1) but produce WE_BANCO=0.
  - Address 0 is never marked busy.
  - An issue to address 0 is ignored.
- Scoreboard:
  - BUSY[i] is set at an edge with ISSUE_VALID and ISSUE_WA=i (i!=0).
  - BUSY[i] is cleared at the edge where a write to i is transferred.
  - Set and clear of the same i at the same edge: set wins (a newer producer exists).
  - Issue to an i already busy and not being cleared that edge: BUSY stays 1 and ISSUE_ERR pulses for the next cycle.
- STALL:
  - STALL = BUSY[RA1_CHK] | BUSY[RA2_CHK], combinational from registered BUSY.
  - Address 0 always reads not-busy.
  - In the cycle after the clearing edge the bank is being written and its write-through makes the new data visible, so no extra stall cycle is needed.
- Reset mid-operation:
  - Pending transfers and busy bits are discarded.
  - The write issued in the reset cycle is lost; WE_BANCO drops immediately.

Decomposition:
- Shared package pkg_jericalla holds:
  - constants NREG, AW, DW;
  - typedef wb_req_t {valid, wa[AW], dw[DW]}, reused by both requesters.
- One sub-module: arbitro_rr2, a 2-way round-robin arbiter with the LAST register.
  - Inputs: req[1:0], advance.
  - Outputs: gnt[1:0], one-hot or zero.
- Scoreboard and output registers stay in the top module.

Test Plan:
- Reset release, REQ0 {WA=5, DW=0xDEADBEEF} valid -> REQ0_READY=1 same cycle; next cycle WE_BANCO=1, WA_BANCO=5, DW_BANCO=0xDEADBEEF; following cycle WE_BANCO=0.
- Both requesters valid continuously (WA=1 and WA=2) for 4 cycles -> grants alternate 0,1,0,1; WA_BANCO sequence 1,2,1,2.
- ISSUE_VALID with WA=7; then RA1_CHK=7 -> STALL=1 and BUSY_VEC[7]=1 until REQ1 writes WA=7; STALL=0 on the cycle WE_BANCO=1 with WA_BANCO=7.
- Same edge: ISSUE_WA=9 and REQ0 transfer to WA=9 (BUSY[9] already 1) -> BUSY[9] remains 1 and ISSUE_ERR stays 0; a second ISSUE_WA=9 without a write -> ISSUE_ERR=1 for one cycle.
- REQ0 write to WA=0 with DW=0x1234 -> REQ0_READY=1, WE_BANCO stays 0; ISSUE_WA=0 -> BUSY_VEC unchanged, STALL=0 for RA1_CHK=0.
- RST_N pulsed low mid-stream with BUSY_VEC=0x0000_0084 and WE_BANCO=1 -> all outputs 0 asynchronously; after release, the first conflict is granted to requester 0.
